// File: rtl/whack_pkg.sv
// Shared types and timing constants for the whack-a-mole player-side logic.
package whack_pkg;

  typedef enum logic [1:0] {IDLE, DOWN, ARMED, WHACKED} scorer_state_t;

  localparam int CLKS_PER_MS = 50000;
  localparam int DEBOUNCE_MS = 10;

endpackage

// File: rtl/whack_hit_scorer_debouncer.sv
// Button conditioner: 2-flop synchroniser, stable-count debounce, rising-edge press pulse.
module button_debouncer #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_press
);

  localparam int CW = $clog2(N + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic          r_db_q;
  logic [CW-1:0] r_cnt;

  // r_db follows the synchronised level only once it has disagreed for a full N-cycle window
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_db_q  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(N)) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_db & ~r_db_q;

endmodule

// File: rtl/whack_hit_scorer.sv
// Player-side scorer: classifies each mole pop as hit, miss or escape and keeps saturating tallies.
module whack_hit_scorer #(
  parameter int CLKS_PER_MS = whack_pkg::CLKS_PER_MS,
  parameter int DEBOUNCE_MS = whack_pkg::DEBOUNCE_MS,
  parameter int SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               reset_button_pressed,
  input  logic               game_in_progress,
  input  logic               mole_clk,
  input  logic               whack_button,
  output logic               mole_show,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic [SCORE_W-1:0] escapes
);

  import whack_pkg::*;

  localparam int N = DEBOUNCE_MS * CLKS_PER_MS;

  scorer_state_t      r_state;
  logic               r_hit;
  logic               r_miss;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] r_misses;
  logic [SCORE_W-1:0] r_escapes;
  logic               w_press;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + SCORE_W'(1);
  endfunction

  button_debouncer #(.N(N)) u_whack_db (
    .clk     (clk),
    .i_rst   (reset_button_pressed),
    .i_raw   (whack_button),
    .o_press (w_press)
  );

  // Losing game_in_progress outranks everything and leaves the tallies on display
  always_ff @(posedge clk) begin
    if (reset_button_pressed) begin
      r_state   <= IDLE;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
      r_score   <= '0;
      r_misses  <= '0;
      r_escapes <= '0;
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      case (r_state)
        IDLE: begin
          if (game_in_progress) begin
            r_score   <= '0;
            r_misses  <= '0;
            r_escapes <= '0;
            r_state   <= mole_clk ? ARMED : DOWN;
          end
        end
        DOWN: begin
          if (!game_in_progress) begin
            r_state <= IDLE;
          end else if (mole_clk) begin
            r_state <= ARMED;
          end else if (w_press) begin
            r_misses <= sat_inc(r_misses);
            r_miss   <= 1'b1;
          end
        end
        ARMED: begin
          if (!game_in_progress) begin
            r_state <= IDLE;
          end else if (w_press) begin
            r_score <= sat_inc(r_score);
            r_hit   <= 1'b1;
            r_state <= WHACKED;
          end else if (!mole_clk) begin
            r_escapes <= sat_inc(r_escapes);
            r_state   <= DOWN;
          end
        end
        WHACKED: begin
          if (!game_in_progress) begin
            r_state <= IDLE;
          end else if (!mole_clk) begin
            r_state <= DOWN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mole_show  = (r_state == ARMED);
  assign hit_pulse  = r_hit;
  assign miss_pulse = r_miss;
  assign score      = r_score;
  assign misses     = r_misses;
  assign escapes    = r_escapes;

endmodule
